memory_access_unit: RTL and testbench

MEM-stage load/store/atomic engine. Consumes the EX/MEM pipeline outputs (address, store data, access type, width, atomic op), runs the access on the data bus with a request/ready handshake, and returns aligned load data to MEM/WB. It stalls the pipeline for the duration of every access and implements RV32A: LR/SC with a single reservation, and AMO read-modify-write.

---
 rtl/memory_access_unit_if.sv | 29 ++
 rtl/memory_access_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_memory_access_unit.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_unit_if.sv
// rtl/memory_access_unit_if.sv - data bus between the memory access unit and memory
// Signals:
//   address      word-aligned byte address (bits [1:0] always zero)
//   write_data   store data already placed in its byte lanes
//   byte_enable  active byte lanes for the access
//   read_enable  read request, held until ready
//   write_enable write request, held until ready
//   read_data    memory word, valid in the cycle ready is high
//   ready        one-cycle completion strobe
// Modports: master = memory_access_unit, slave = memory model / bus fabric.
interface memory_access_unit_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [3:0]  byte_enable;
  logic        read_enable;
  logic        write_enable;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output address, write_data, byte_enable, read_enable, write_enable,
    input  read_data, ready
  );

  modport slave (
    input  address, write_data, byte_enable, read_enable, write_enable,
    output read_data, ready
  );
endinterface

// File: rtl/memory_access_unit.sv
// rtl/memory_access_unit.sv - MEM-stage load/store/atomic engine with LR/SC and AMO
// Ports:
//   clock, reset                 clock and synchronous active-high reset
//   mem_result                   byte address of the access
//   mem_rs2_data_forwarded       store data / AMO operand
//   mem_mem_read, mem_mem_write  load / store request
//   mem_mem_op_length            funct3 width: B, H, W, BU, HU
//   mem_atomic_op                RV32A funct5, all ones when not atomic
//   stall                        holds the upstream pipeline while an access is in flight
//   load_data                    extended load value, AMO old value or SC status
//   misaligned                   one-cycle pulse for a misaligned access
//   bus                          data bus (master side)
module memory_access_unit (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          mem_result,
  input  logic [31:0]          mem_rs2_data_forwarded,
  input  logic                 mem_mem_read,
  input  logic                 mem_mem_write,
  input  logic [2:0]           mem_mem_op_length,
  input  logic [4:0]           mem_atomic_op,
  output logic                 stall,
  output logic [31:0]          load_data,
  output logic                 misaligned,
  memory_access_unit_if.master bus
);
  localparam logic [4:0] ATOMIC_NO_OP = 5'b11111;
  localparam logic [4:0] ATOMIC_ADD   = 5'b00000;
  localparam logic [4:0] ATOMIC_SWAP  = 5'b00001;
  localparam logic [4:0] ATOMIC_LR    = 5'b00010;
  localparam logic [4:0] ATOMIC_SC    = 5'b00011;
  localparam logic [4:0] ATOMIC_XOR   = 5'b00100;
  localparam logic [4:0] ATOMIC_OR    = 5'b01000;
  localparam logic [4:0] ATOMIC_AND   = 5'b01100;
  localparam logic [4:0] ATOMIC_MIN   = 5'b10000;
  localparam logic [4:0] ATOMIC_MAX   = 5'b10100;
  localparam logic [4:0] ATOMIC_MINU  = 5'b11000;
  localparam logic [4:0] ATOMIC_MAXU  = 5'b11100;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    READ      = 3'd1,
    WRITE     = 3'd2,
    AMO_READ  = 3'd3,
    AMO_WRITE = 3'd4,
    DONE      = 3'd5
  } state_t;

  state_t      state;
  logic        res_valid;
  logic [29:0] res_addr;

  logic        is_atomic;
  logic        is_lr;
  logic        is_sc;
  logic        access;
  logic        aligned;
  logic        res_hit;
  logic [3:0]  lane_mask;
  logic [31:0] lane_data;
  logic [31:0] rd_shift;
  logic [15:0] rd_half;
  logic [31:0] load_ext;
  logic [31:0] amo_new;
  logic [31:0] word_address;

  assign is_atomic    = (mem_atomic_op != ATOMIC_NO_OP);
  assign is_lr        = (mem_atomic_op == ATOMIC_LR);
  assign is_sc        = (mem_atomic_op == ATOMIC_SC);
  assign access       = mem_mem_read | mem_mem_write | is_atomic;
  assign res_hit      = res_valid && (res_addr == mem_result[31:2]);
  assign word_address = {mem_result[31:2], 2'b00};

  assign stall = ((state == IDLE) && access) || ((state != IDLE) && (state != DONE));

  // Alignment, byte lanes and lane-replicated store data for the access width.
  always_comb begin
    aligned   = 1'b1;
    lane_mask = 4'b1111;
    lane_data = mem_rs2_data_forwarded;
    if (is_atomic) begin
      aligned = (mem_result[1:0] == 2'b00);
    end else begin
      case (mem_mem_op_length[1:0])
        2'b00: begin
          lane_mask = 4'b0001 << mem_result[1:0];
          lane_data = {4{mem_rs2_data_forwarded[7:0]}};
        end
        2'b01: begin
          aligned   = ~mem_result[0];
          lane_mask = 4'b0011 << mem_result[1:0];
          lane_data = {2{mem_rs2_data_forwarded[15:0]}};
        end
        default: begin
          aligned = (mem_result[1:0] == 2'b00);
        end
      endcase
    end
  end

  // Load lane selection and extension; atomics always see the full word.
  always_comb begin
    rd_shift = bus.read_data >> {mem_result[1:0], 3'b000};
    rd_half  = mem_result[1] ? bus.read_data[31:16] : bus.read_data[15:0];
    load_ext = bus.read_data;
    if (!is_atomic) begin
      case (mem_mem_op_length)
        3'b000:  load_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
        3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
        3'b100:  load_ext = {24'd0, rd_shift[7:0]};
        3'b101:  load_ext = {16'd0, rd_half};
        default: load_ext = bus.read_data;
      endcase
    end
  end

  always_comb begin
    amo_new = mem_rs2_data_forwarded;
    case (mem_atomic_op)
      ATOMIC_ADD:  amo_new = bus.read_data + mem_rs2_data_forwarded;
      ATOMIC_SWAP: amo_new = mem_rs2_data_forwarded;
      ATOMIC_XOR:  amo_new = bus.read_data ^ mem_rs2_data_forwarded;
      ATOMIC_OR:   amo_new = bus.read_data | mem_rs2_data_forwarded;
      ATOMIC_AND:  amo_new = bus.read_data & mem_rs2_data_forwarded;
      ATOMIC_MIN:  amo_new = ($signed(bus.read_data) < $signed(mem_rs2_data_forwarded)) ?
                             bus.read_data : mem_rs2_data_forwarded;
      ATOMIC_MAX:  amo_new = ($signed(bus.read_data) > $signed(mem_rs2_data_forwarded)) ?
                             bus.read_data : mem_rs2_data_forwarded;
      ATOMIC_MINU: amo_new = (bus.read_data < mem_rs2_data_forwarded) ?
                             bus.read_data : mem_rs2_data_forwarded;
      ATOMIC_MAXU: amo_new = (bus.read_data > mem_rs2_data_forwarded) ?
                             bus.read_data : mem_rs2_data_forwarded;
      default:     amo_new = mem_rs2_data_forwarded;
    endcase
  end

  // The mem_* inputs are held stable while stall is high, so every state
  // can keep decoding them directly instead of latching a copy at IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      load_data        <= 32'd0;
      misaligned       <= 1'b0;
      bus.address      <= 32'd0;
      bus.write_data   <= 32'd0;
      bus.byte_enable  <= 4'd0;
      bus.read_enable  <= 1'b0;
      bus.write_enable <= 1'b0;
      res_valid        <= 1'b0;
      res_addr         <= 30'd0;
    end else begin
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            if (!aligned) begin
              misaligned <= 1'b1;
              load_data  <= 32'd0;
              state      <= DONE;
            end else if (is_sc) begin
              if (res_hit) begin
                bus.address      <= word_address;
                bus.write_data   <= mem_rs2_data_forwarded;
                bus.byte_enable  <= 4'b1111;
                bus.write_enable <= 1'b1;
                state            <= WRITE;
              end else begin
                load_data <= 32'd1;
                state     <= DONE;
              end
            end else if (is_atomic) begin
              bus.address     <= word_address;
              bus.byte_enable <= 4'b1111;
              bus.read_enable <= 1'b1;
              state           <= is_lr ? READ : AMO_READ;
            end else if (mem_mem_write) begin
              bus.address      <= word_address;
              bus.write_data   <= lane_data;
              bus.byte_enable  <= lane_mask;
              bus.write_enable <= 1'b1;
              state            <= WRITE;
            end else begin
              bus.address     <= word_address;
              bus.byte_enable <= lane_mask;
              bus.read_enable <= 1'b1;
              state           <= READ;
            end
          end
        end
        READ: begin
          if (bus.ready) begin
            bus.read_enable <= 1'b0;
            load_data       <= load_ext;
            if (is_lr) begin
              res_valid <= 1'b1;
              res_addr  <= mem_result[31:2];
            end
            state <= DONE;
          end
        end
        WRITE: begin
          if (bus.ready) begin
            bus.write_enable <= 1'b0;
            if (is_sc) begin
              load_data <= 32'd0;
              res_valid <= 1'b0;
            end else if (res_hit) begin
              res_valid <= 1'b0;
            end
            state <= DONE;
          end
        end
        AMO_READ: begin
          // Read drops and write rises on the same edge, so the two enables never overlap.
          if (bus.ready) begin
            bus.read_enable  <= 1'b0;
            load_data        <= bus.read_data;
            bus.write_data   <= amo_new;
            bus.write_enable <= 1'b1;
            state            <= AMO_WRITE;
          end
        end
        AMO_WRITE: begin
          if (bus.ready) begin
            bus.write_enable <= 1'b0;
            if (res_hit) begin
              res_valid <= 1'b0;
            end
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_access_unit.sv
// tb/tb_memory_access_unit.sv - directed self-checking bench for memory_access_unit
module tb_memory_access_unit;
  localparam logic [4:0] NO_OP = 5'b11111;
  localparam logic [4:0] A_ADD = 5'b00000;
  localparam logic [4:0] A_LR  = 5'b00010;
  localparam logic [4:0] A_SC  = 5'b00011;
  localparam logic [4:0] A_XOR = 5'b00100;
  localparam logic [4:0] A_MIN = 5'b10000;
  localparam logic [4:0] A_MAX = 5'b10100;
  localparam logic [4:0] A_MAXU = 5'b11100;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] mem_result;
  logic [31:0] mem_rs2_data_forwarded;
  logic        mem_mem_read;
  logic        mem_mem_write;
  logic [2:0]  mem_mem_op_length;
  logic [4:0]  mem_atomic_op;
  logic        stall;
  logic [31:0] load_data;
  logic        misaligned;

  memory_access_unit_if bus ();

  memory_access_unit dut (
    .clock                  (clock),
    .reset                  (reset),
    .mem_result             (mem_result),
    .mem_rs2_data_forwarded (mem_rs2_data_forwarded),
    .mem_mem_read           (mem_mem_read),
    .mem_mem_write          (mem_mem_write),
    .mem_mem_op_length      (mem_mem_op_length),
    .mem_atomic_op          (mem_atomic_op),
    .stall                  (stall),
    .load_data              (load_data),
    .misaligned             (misaligned),
    .bus                    (bus)
  );

  always #5 clock = ~clock;

  // Bus responder: ready after bus_wait idle cycles of a held enable.
  logic [31:0] bus_word;
  int          bus_wait;
  int          wait_cnt = 0;
  int          n_writes = 0;
  logic [31:0] last_wdata = 32'd0;

  assign bus.read_data = bus_word;
  assign bus.ready     = (bus.read_enable | bus.write_enable) && (wait_cnt >= bus_wait);

  always @(posedge clock) begin
    if ((bus.read_enable | bus.write_enable) && !bus.ready) wait_cnt <= wait_cnt + 1;
    else wait_cnt <= 0;
    if (bus.write_enable && bus.ready) begin
      n_writes   <= n_writes + 1;
      last_wdata <= bus.write_data;
    end
  end

  int total = 0;
  int bad = 0;

  int          r_stall;
  int          r_en;
  int          r_writes;
  logic [3:0]  r_be;
  logic [31:0] r_addr;
  logic        r_both;
  logic        r_mis;
  logic [31:0] r_ld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    mem_result             = 32'd0;
    mem_rs2_data_forwarded = 32'd0;
    mem_mem_read           = 1'b0;
    mem_mem_write          = 1'b0;
    mem_mem_op_length      = 3'b010;
    mem_atomic_op          = NO_OP;
  endtask

  // Starts at a negedge with the FSM in IDLE; returns after the DONE cycle.
  task automatic run(input logic [31:0] a, input logic [31:0] d, input logic rd, input logic wr,
                     input logic [2:0] len, input logic [4:0] op, input int waits,
                     input logic [31:0] word);
    int w0;
    w0       = n_writes;
    bus_wait = waits;
    bus_word = word;
    mem_result = a; mem_rs2_data_forwarded = d; mem_mem_read = rd; mem_mem_write = wr;
    mem_mem_op_length = len; mem_atomic_op = op;
    r_stall = 0; r_en = 0; r_be = 4'd0; r_addr = 32'd0; r_both = 1'b0; r_mis = 1'b0;
    #1;
    while (stall && r_stall < 100) begin
      r_stall++;
      @(negedge clock);
      if (bus.read_enable | bus.write_enable) begin
        r_en++;
        r_be   = bus.byte_enable;
        r_addr = bus.address;
      end
      if (bus.read_enable & bus.write_enable) r_both = 1'b1;
    end
    r_ld     = load_data;
    r_mis    = misaligned;
    r_writes = n_writes - w0;
    idle_inputs();
    @(negedge clock);
  endtask

  initial begin
    reset = 1'b1;
    bus_wait = 0;
    bus_word = 32'd0;
    idle_inputs();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_load_data", load_data, 32'd0);
    chk("rst_misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst_address", bus.address, 32'd0);
    chk("rst_byte_enable", {28'd0, bus.byte_enable}, 32'd0);
    chk("rst_enables", {30'd0, bus.read_enable, bus.write_enable}, 32'd0);

    // LB 0x1003, zero-wait
    run(32'h1003, 32'd0, 1'b1, 1'b0, 3'b000, NO_OP, 0, 32'h80FF_1234);
    chk("lb_data", r_ld, 32'hFFFF_FF80);
    chk("lb_stall", r_stall, 2);
    chk("lb_en_cycles", r_en, 1);
    chk("lb_be", {28'd0, r_be}, 32'h8);
    chk("lb_addr", r_addr, 32'h1000);

    // LHU 0x1002 and LH 0x1000
    run(32'h1002, 32'd0, 1'b1, 1'b0, 3'b101, NO_OP, 0, 32'h80FF_1234);
    chk("lhu_data", r_ld, 32'h0000_80FF);
    run(32'h1000, 32'd0, 1'b1, 1'b0, 3'b001, NO_OP, 1, 32'h80FF_8234);
    chk("lh_data", r_ld, 32'hFFFF_8234);
    chk("lh_stall", r_stall, 3);

    // SH 0x2002, 3 wait cycles
    run(32'h2002, 32'h0000_ABCD, 1'b0, 1'b1, 3'b001, NO_OP, 3, 32'd0);
    chk("sh_be", {28'd0, r_be}, 32'hC);
    chk("sh_wdata", last_wdata, 32'hABCD_ABCD);
    chk("sh_en_cycles", r_en, 4);
    chk("sh_stall", r_stall, 5);
    chk("sh_writes", r_writes, 1);

    // SB 0x2001
    run(32'h2001, 32'h0000_005A, 1'b0, 1'b1, 3'b000, NO_OP, 0, 32'd0);
    chk("sb_be", {28'd0, r_be}, 32'h2);
    chk("sb_wdata", last_wdata, 32'h5A5A_5A5A);

    // LW misaligned
    run(32'h2001, 32'd0, 1'b1, 1'b0, 3'b010, NO_OP, 0, 32'hFFFF_FFFF);
    chk("lw_mis_pulse", {31'd0, r_mis}, 32'd1);
    chk("lw_mis_en", r_en, 0);
    chk("lw_mis_data", r_ld, 32'd0);
    chk("lw_mis_stall", r_stall, 1);
    @(negedge clock);
    chk("lw_mis_pulse_end", {31'd0, misaligned}, 32'd0);

    // AMOADD 0x100: 5 + 7
    run(32'h100, 32'd7, 1'b0, 1'b0, 3'b010, A_ADD, 0, 32'd5);
    chk("amoadd_wdata", last_wdata, 32'd12);
    chk("amoadd_old", r_ld, 32'd5);
    chk("amoadd_stall", r_stall, 3);
    chk("amoadd_writes", r_writes, 1);
    chk("amoadd_be", {28'd0, r_be}, 32'hF);
    chk("amoadd_no_overlap", {31'd0, r_both}, 32'd0);

    // Signed vs unsigned compares, XOR
    run(32'h104, 32'd3, 1'b0, 1'b0, 3'b010, A_MAX, 0, 32'hFFFF_FFFE);
    chk("amomax_wdata", last_wdata, 32'd3);
    run(32'h104, 32'd3, 1'b0, 1'b0, 3'b010, A_MAXU, 0, 32'hFFFF_FFFE);
    chk("amomaxu_wdata", last_wdata, 32'hFFFF_FFFE);
    run(32'h104, 32'd3, 1'b0, 1'b0, 3'b010, A_MIN, 0, 32'hFFFF_FFFE);
    chk("amomin_wdata", last_wdata, 32'hFFFF_FFFE);
    run(32'h108, 32'h0000_00FF, 1'b0, 1'b0, 3'b010, A_XOR, 0, 32'h0000_F0F0);
    chk("amoxor_wdata", last_wdata, 32'h0000_F00F);
    chk("amoxor_old", r_ld, 32'h0000_F0F0);

    // Misaligned atomic
    run(32'h102, 32'd1, 1'b0, 1'b0, 3'b010, A_ADD, 0, 32'd0);
    chk("amo_mis_pulse", {31'd0, r_mis}, 32'd1);
    chk("amo_mis_writes", r_writes, 0);

    // LR then SC succeeds, second SC fails
    run(32'h200, 32'd0, 1'b0, 1'b0, 3'b010, A_LR, 0, 32'hDEAD_BEEF);
    chk("lr_data", r_ld, 32'hDEAD_BEEF);
    run(32'h200, 32'h55, 1'b0, 1'b0, 3'b010, A_SC, 0, 32'd0);
    chk("sc1_status", r_ld, 32'd0);
    chk("sc1_writes", r_writes, 1);
    chk("sc1_wdata", last_wdata, 32'h55);
    chk("sc1_stall", r_stall, 2);
    run(32'h200, 32'h66, 1'b0, 1'b0, 3'b010, A_SC, 0, 32'd0);
    chk("sc2_status", r_ld, 32'd1);
    chk("sc2_writes", r_writes, 0);
    chk("sc2_stall", r_stall, 1);

    // LR, intervening store to the reserved word, SC fails
    run(32'h300, 32'd0, 1'b0, 1'b0, 3'b010, A_LR, 0, 32'h1111_2222);
    run(32'h300, 32'h77, 1'b0, 1'b1, 3'b010, NO_OP, 0, 32'd0);
    run(32'h300, 32'h88, 1'b0, 1'b0, 3'b010, A_SC, 0, 32'd0);
    chk("sc3_status", r_ld, 32'd1);
    chk("sc3_writes", r_writes, 0);

    // Reset while a write waits for ready
    bus_wait = 5;
    mem_result = 32'h400; mem_rs2_data_forwarded = 32'h99; mem_mem_write = 1'b1;
    mem_mem_op_length = 3'b010;
    repeat (2) @(negedge clock);
    chk("mid_we_high", {31'd0, bus.write_enable}, 32'd1);
    reset = 1'b1;
    idle_inputs();
    @(negedge clock);
    chk("mid_rst_enables", {30'd0, bus.read_enable, bus.write_enable}, 32'd0);
    chk("mid_rst_stall", {31'd0, stall}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run(32'h404, 32'd0, 1'b1, 1'b0, 3'b010, NO_OP, 0, 32'h1234_5678);
    chk("post_rst_lw", r_ld, 32'h1234_5678);
    chk("post_rst_stall", r_stall, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
